// File: rtl/codebreak_pkg.sv
// Shared types and sizing for the CodeBreak guess scorer.
package codebreak_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int MAX_TRIES  = 8;
  localparam int NUM_COLORS = 10;

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int ATT_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef digit_t [NUM_DIGITS-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXACT   = 2'd1,
    PARTIAL = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/codebreak_partial_find.sv
// Finds the highest-index secret digit that is still unused and equals g.
module codebreak_partial_find
  import codebreak_pkg::*;
(
  input  digit_t                  g,
  input  code_t                   s,
  input  logic [NUM_DIGITS-1:0]   sec_used,
  output logic                    found,
  output logic [IDX_W-1:0]        j
);

  logic [NUM_DIGITS-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hit
      assign hit[gi] = !sec_used[gi] && (s[gi] == g);
    end
  endgenerate

  // Ascending scan: the last hit seen is the highest index.
  always_comb begin
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        found = 1'b1;
        j     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/codebreak_scorer.sv
// Sequential guess scorer for CodeBreak: exact pass, partial pass, then result.
// Optional digit-range check on guesses: define CODEBREAK_GUESS_CHECK_EN.
module codebreak_scorer
  import codebreak_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  secret_in,
  input  logic                           load_secret,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  guess_in,
  input  logic                           guess_valid,
  output logic                           guess_ready,
  output logic                           result_valid,
  output logic [CNT_W-1:0]               exact_cnt,
  output logic [CNT_W-1:0]               partial_cnt,
  output logic [ATT_W-1:0]               attempts,
  output logic                           win,
  output logic                           game_over
`ifdef CODEBREAK_GUESS_CHECK_EN
  ,
  output logic                           guess_err
`endif
);

  state_t                 state_reg;
  logic [IDX_W-1:0]       idx_reg;
  code_t                  secret_reg;
  code_t                  guess_reg;
  logic [NUM_DIGITS-1:0]  sec_used_reg;
  logic [NUM_DIGITS-1:0]  gss_used_reg;
  logic [CNT_W-1:0]       exact_acc_reg;
  logic [CNT_W-1:0]       partial_acc_reg;
  logic                   secret_loaded_reg;

  logic                   guess_take;
  logic                   guess_score;
  digit_t                 cur_guess;
  logic                   pf_found;
  logic [IDX_W-1:0]       pf_j;
  logic                   partial_inc;
  logic [CNT_W-1:0]       partial_final;
  logic [ATT_W-1:0]       attempts_next;
  logic                   win_now;

  assign guess_ready = (state_reg == IDLE) && secret_loaded_reg && !game_over && !load_secret;
  assign guess_take  = guess_valid && guess_ready;

`ifdef CODEBREAK_GUESS_CHECK_EN
  code_t                 guess_code;
  logic [NUM_DIGITS-1:0] digit_bad;

  assign guess_code = guess_in;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_range
      assign digit_bad[gi] = (int'(guess_code[gi]) >= NUM_COLORS);
    end
  endgenerate

  // Out-of-range guesses are consumed at the handshake but never scored.
  assign guess_score = guess_take && !(|digit_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guess_err <= 1'b0;
    end else begin
      guess_err <= guess_take && (|digit_bad);
    end
  end
`else
  assign guess_score = guess_take;
`endif

  assign cur_guess = guess_reg[idx_reg];

  codebreak_partial_find u_partial_find (
    .g        (cur_guess),
    .s        (secret_reg),
    .sec_used (sec_used_reg),
    .found    (pf_found),
    .j        (pf_j)
  );

  assign partial_inc   = (state_reg == PARTIAL) && !gss_used_reg[idx_reg] && pf_found;
  assign partial_final = partial_acc_reg + {{(CNT_W-1){1'b0}}, partial_inc};
  assign attempts_next = (attempts == ATT_W'(MAX_TRIES)) ? attempts : attempts + ATT_W'(1);
  assign win_now       = (exact_acc_reg == CNT_W'(NUM_DIGITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      secret_reg        <= '0;
      guess_reg         <= '0;
      sec_used_reg      <= '0;
      gss_used_reg      <= '0;
      exact_acc_reg     <= '0;
      partial_acc_reg   <= '0;
      secret_loaded_reg <= 1'b0;
      result_valid      <= 1'b0;
      exact_cnt         <= '0;
      partial_cnt       <= '0;
      attempts          <= '0;
      win               <= 1'b0;
      game_over         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (load_secret) begin
        // New game: aborts any scoring run in flight without a result.
        secret_reg        <= secret_in;
        secret_loaded_reg <= 1'b1;
        attempts          <= '0;
        win               <= 1'b0;
        game_over         <= 1'b0;
        exact_cnt         <= '0;
        partial_cnt       <= '0;
        state_reg         <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (guess_score) begin
              guess_reg       <= guess_in;
              exact_acc_reg   <= '0;
              partial_acc_reg <= '0;
              sec_used_reg    <= '0;
              gss_used_reg    <= '0;
              idx_reg         <= IDX_W'(NUM_DIGITS - 1);
              state_reg       <= EXACT;
            end
          end
          EXACT: begin
            if (guess_reg[idx_reg] == secret_reg[idx_reg]) begin
              exact_acc_reg         <= exact_acc_reg + CNT_W'(1);
              sec_used_reg[idx_reg] <= 1'b1;
              gss_used_reg[idx_reg] <= 1'b1;
            end
            if (idx_reg == '0) begin
              idx_reg   <= IDX_W'(NUM_DIGITS - 1);
              state_reg <= PARTIAL;
            end else begin
              idx_reg <= idx_reg - IDX_W'(1);
            end
          end
          PARTIAL: begin
            if (partial_inc) begin
              partial_acc_reg    <= partial_final;
              sec_used_reg[pf_j] <= 1'b1;
            end
            if (idx_reg == '0) begin
              // Results are registered here so they are visible during the DONE cycle.
              exact_cnt    <= exact_acc_reg;
              partial_cnt  <= partial_final;
              result_valid <= 1'b1;
              attempts     <= attempts_next;
              if (win_now) begin
                win <= 1'b1;
              end
              if (win_now || (attempts_next == ATT_W'(MAX_TRIES))) begin
                game_over <= 1'b1;
              end
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg - IDX_W'(1);
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
